i2c_target: RTL and testbench
=============================

# i2c_target

Synchronous I2C target (slave) for register access from an I2C controller, such as the board-level configuration master that writes 24-bit address/register/data frames. Sits on the FPGA side of the I2C pins. It oversamples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit device address, and ACKs bytes. Writes are presented as single-cycle strobes to a local register file; reads return a byte from that register file.

## Interface
- DEV_ADDR, 7'h1A: 7-bit device address; the write address byte is 8'h34.
- clk  input  1  system clock; must be ≥ 8× the SCL frequency.
- rst  input  1  asynchronous, active-high reset.
- i2c_sclk  input  1  I2C clock from the controller; the target never stretches it.
- i2c_sdat  inout  1  I2C data, open-drain; driven 0 or released to 1'bz.
- wr_en  output  1  one-cycle write strobe.
- wr_addr  output  8  register address qualified by wr_en.
- wr_data  output  8  write data qualified by wr_en.
- rd_addr  output  8  current register pointer, for combinational read-back.
- rd_data  input  8  register-file data at rd_addr.
- busy  output  1  high from an addressed START until STOP.

## Operation
- **Input sampling**
  - SCL and SDA each pass through a 2-FF synchronizer, then a third register for edge detection.
  - All decisions use the synchronized values.
- **Bus conditions**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - START from any state, including a repeated START, goes to ADDR, clears the bit counter, and releases SDA.
  - STOP from any state goes to IDLE, releases SDA, and clears busy.
- **Bit handling**
  - Data bits are sampled on the SCL rising edge, MSB first.
  - The target changes SDA only on a detected SCL falling edge.
- **States**
  - IDLE: SDA released; waits for START.
  - ADDR: shifts 8 bits. At the 8th falling edge:
    - bits[7:1]==DEV_ADDR: go to ACK_ADDR and drive SDA=0; busy=1.
    - otherwise: go to IGNORE with SDA released.
  - IGNORE: SDA released until START or STOP.
  - ACK_ADDR: at the next falling edge, release SDA.
    - R/W=0: go to REG.
    - R/W=1: go to RDATA. rd_data is loaded into the shift register and bit 7 is driven on that same edge.
  - REG: shifts 8 bits. At the 8th falling edge, rd_addr is loaded with the byte, SDA is driven 0, and the state goes to ACK_REG.
  - ACK_REG: at the next falling edge, release SDA and go to WDATA.
  - WDATA: shifts 8 bits. At the 8th falling edge:
    - wr_en=1 for exactly one clk, with wr_addr=rd_addr and wr_data=the byte.
    - rd_addr increments by 1, wrapping 8'hFF→8'h00.
    - SDA is driven 0; go to ACK_WDATA.
  - ACK_WDATA: at the next falling edge, release SDA and return to WDATA. Further bytes are written to consecutive addresses.
  - RDATA: SDA drives the shift-register MSB (a 1 is released, a 0 is pulled low). On each falling edge the register shifts.
    - After 8 bits, SDA is released, rd_addr increments, and the state goes to MACK.
  - MACK: on the rising edge, sample SDA.
    - 0 (ACK): at the next falling edge, load rd_data, drive bit 7, and go to RDATA.
    - 1 (NACK): go to IGNORE and wait for STOP.
- **Pointer**
  - rd_addr persists across transactions; it resets only on rst.
  - A read without a preceding REG phase uses the current pointer.
- **Restrictions**
  - General call and 10-bit addressing are not supported. Address 8'h00 goes to IGNORE unless DEV_ADDR==0.

## Timing
- Reset values:
  - state=IDLE; i2c_sdat=z.
  - wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0.
- The target responds 3 clk after the pin edge (2 synchronizer stages + 1 edge register).
- SDA is driven or released within 1 clk of the detected SCL fall. This gives the controller at least 3 clk of hold.
- wr_en asserts 1 clk after the 8th detected SCL fall of a WDATA byte.
  - wr_addr and wr_data are valid in that cycle and held until the next strobe.
- rd_data is sampled once per byte, at the load edge. Changes to rd_data mid-byte are ignored.
- If STOP or START arrives mid-byte, the partial byte is discarded: no wr_en, no pointer update.
- If START or STOP coincides with an SCL edge in the same clk, the bus condition wins.
- rst mid-transfer takes effect immediately: SDA released, all outputs at reset values. The target then waits for a fresh START; bus activity before that START is ignored.

## Test plan
- Write 8'h34, 8'h0E, 8'h42 then STOP:
  - three ACKs (SDA=0 in the 9th clock of each byte);
  - exactly one wr_en with wr_addr=8'h0E, wr_data=8'h42;
  - busy 1→0 at STOP.
- Address 8'h36 followed by two bytes: SDA never driven low, no wr_en, busy stays 0.
- Write 8'h34, 8'hFE, 8'hA1, 8'hB2, 8'hC3 → wr_en at addresses FE, FF, 00 with data A1, B2, C3; rd_addr=8'h01 afterwards.
- Write 8'h34, 8'h05, repeated START, 8'h35 with rd_data=8'h5A at addr 05 and 8'hC3 at addr 06; controller ACKs byte 1 and NACKs byte 2:
  - SDA carries 5A then C3;
  - SDA is released after the NACK;
  - rd_addr=8'h07 after STOP.
- STOP after 4 bits of a data byte → no wr_en, rd_addr unchanged, state IDLE. The next full write frame completes normally.
- Assert rst during the ACK_REG bit → SDA released the next cycle, all outputs at reset values. A subsequent frame of 34/10/55 gives wr_en with wr_addr=8'h10, wr_data=8'h55.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) giving an I2C controller byte access to a
// local register file.
//
// SCL and SDA are oversampled on clk. clk must run at least 8x the SCL rate.
// The block decodes START and STOP, matches a 7-bit device address and ACKs
// each byte. Write data leaves as a single-cycle strobe. Read data is taken
// from rd_data at the address on rd_addr.
//
// Ports
//   clk      system clock
//   rst      asynchronous active-high reset
//   i2c_sclk I2C clock from the controller (never stretched)
//   i2c_sdat I2C data, open-drain: driven 0 or released to z
//   wr_en    one-cycle write strobe
//   wr_addr  register address for wr_en (held until the next strobe)
//   wr_data  register data for wr_en (held until the next strobe)
//   rd_addr  current register pointer
//   rd_data  register-file contents at rd_addr
//   busy     high from an addressed START until STOP
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ACK_ADDR, ST_IGNORE, ST_REG,
        ST_ACK_REG, ST_WDATA, ST_ACK_WDATA, ST_RDATA, ST_MACK
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] scl_sync_q, scl_sync_d;
    logic [2:0] sda_sync_q, sda_sync_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rd_addr_q, rd_addr_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_en_q, wr_en_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       mack_ack_q, mack_ack_d;

    // Bits [1:0] of each chain are the two synchronizer stages.
    // Bit [2] holds the previous synchronized value, used for edge detection.
    assign scl_sync_d = {scl_sync_q[1:0], i2c_sclk};
    assign sda_sync_d = {sda_sync_q[1:0], i2c_sdat};

    logic scl_now, scl_prev, sda_now, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_now   = scl_sync_q[1];
    assign scl_prev  = scl_sync_q[2];
    assign sda_now   = sda_sync_q[1];
    assign sda_prev  = sda_sync_q[2];
    assign scl_rise  = scl_now & ~scl_prev;
    assign scl_fall  = ~scl_now & scl_prev;
    // SCL must be high in both samples, so a bus condition never coincides
    // with an SCL edge in the same clk.
    assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
    assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        mack_ack_d = mack_ack_q;

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_now};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ST_ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_d  = ST_ACK_ADDR;
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else if (state_q == ST_REG) begin
                            rd_addr_d = shift_q;
                            sda_oe_d  = 1'b1;
                            state_d   = ST_ACK_REG;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = rd_addr_q;
                            wr_data_d = shift_q;
                            rd_addr_d = rd_addr_q + 8'd1;
                            sda_oe_d  = 1'b1;
                            state_d   = ST_ACK_WDATA;
                        end
                    end
                end
                ST_ACK_ADDR: begin
                    if (scl_fall) begin
                        // shift_q still holds the address byte; bit 0 is R/W.
                        if (shift_q[0]) begin
                            shift_d   = rd_data;
                            sda_oe_d  = ~rd_data[7];
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_REG;
                        end
                    end
                end
                ST_ACK_REG, ST_ACK_WDATA: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            // Last bit's clock is over: let the controller ACK.
                            sda_oe_d   = 1'b0;
                            rd_addr_d  = rd_addr_q + 8'd1;
                            mack_ack_d = 1'b0;
                            bit_cnt_d  = 4'd0;
                            state_d    = ST_MACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_MACK: begin
                    if (scl_rise) begin
                        if (sda_now) state_d = ST_IGNORE;
                        else         mack_ack_d = 1'b1;
                    end else if (scl_fall && mack_ack_q) begin
                        shift_d   = rd_data;
                        sda_oe_d  = ~rd_data[7];
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RDATA;
                    end
                end
                default: ;  // IDLE and IGNORE wait for a bus condition
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            scl_sync_q <= 3'b111;   // idle bus level avoids false edges
            sda_sync_q <= 3'b111;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            rd_addr_q  <= 8'd0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            wr_en_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            mack_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            mack_ack_q <= mack_ack_d;
        end
    end

    assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_addr  = rd_addr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bench for i2c_target. It models an I2C controller on an
// open-drain SDA line with a pullup, and a register file that feeds rd_data.
// Expected write strobes and read bytes are queued as stimulus is issued.
// They are popped and compared when the target produces them.
module tb_i2c_target;

    localparam int Q = 5;    // clk cycles from SCL fall to controller SDA change
    localparam int H = 10;   // clk cycles SCL stays high

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_low;
    wire        sda_bus;
    logic       wr_en;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic       busy;
    logic [7:0] reg_mem [256];

    int errors = 0;
    int checks = 0;
    int dut_low_cnt = 0;
    logic [15:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];

    pullup (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    assign rd_data = reg_mem[rd_addr];

    always #5 clk = ~clk;

    i2c_target #(.DEV_ADDR(7'h1A)) dut (
        .clk      (clk),
        .rst      (rst),
        .i2c_sclk (scl),
        .i2c_sdat (sda_bus),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    // Write-strobe scoreboard. A strobe held for two cycles pops twice and
    // shows up as an unexpected write.
    always @(negedge clk) begin
        if (!sda_low && sda_bus === 1'b0) dut_low_cnt++;
        if (!rst && wr_en === 1'b1) begin
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", wr_addr, wr_data);
            end else begin
                logic [15:0] exp;
                exp = exp_wr_q.pop_front();
                if ({wr_addr, wr_data} !== exp) begin
                    errors++;
                    $display("FAIL wr_strobe: got addr=%h data=%h, required addr=%h data=%h",
                             wr_addr, wr_data, exp[15:8], exp[7:0]);
                end else begin
                    $display("write addr=%h data=%h", wr_addr, wr_data);
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL clock. The controller drives b (1 = release) and samples the bus
    // in mid-high.
    task automatic bit_xfer(input logic b, output logic s);
        sda_low = ~b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(H / 2);
        s = sda_bus;
        wait_clk(H / 2);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0;
        wait_clk(H);
        scl = 1'b1;
        wait_clk(H);
        sda_low = 1'b1;
        wait_clk(H);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(H);
        sda_low = 1'b0;
        wait_clk(H);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            b[i] = s;
        end
        bit_xfer(~ack, s);
    endtask

    task automatic test_reset();
        rst = 1'b1; scl = 1'b1; sda_low = 1'b0;
        wait_clk(3);
        checks++;
        if ({wr_en, wr_addr, wr_data, rd_addr, busy} !== 26'd0 || sda_bus !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got wr_en=%b wr_addr=%h wr_data=%h rd_addr=%h busy=%b sda=%b, required all 0 and sda=1",
                     wr_en, wr_addr, wr_data, rd_addr, busy, sda_bus);
        end
        rst = 1'b0;
        wait_clk(H);
    endtask

    task automatic test_write();
        logic [7:0] frame [3] = '{8'h34, 8'h0E, 8'h42};
        logic ack;
        exp_wr_q.push_back({8'h0E, 8'h42});
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            write_byte(frame[i], ack);
            checks++;
            if (ack !== 1'b1) begin
                errors++;
                $display("FAIL write_ack byte %0d: got ack=%b, required 1", i, ack);
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL write_busy_high: got %b, required 1", busy);
        end
        i2c_stop();
        checks++;
        if (busy !== 1'b0 || rd_addr !== 8'h0F || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL write_after_stop: got busy=%b rd_addr=%h pending=%0d, required busy=0 rd_addr=0f pending=0",
                     busy, rd_addr, exp_wr_q.size());
        end
    endtask

    task automatic test_addr_mismatch();
        logic [7:0] frame [3] = '{8'h36, 8'h11, 8'h22};
        logic ack;
        int low0;
        low0 = dut_low_cnt;
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            write_byte(frame[i], ack);
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL mismatch_ack byte %0d: got ack=%b, required 0", i, ack);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_busy: got %b, required 0", busy);
        end
        i2c_stop();
        checks++;
        if (dut_low_cnt != low0 || rd_addr !== 8'h0F) begin
            errors++;
            $display("FAIL mismatch_quiet: got sda_low_cycles=%0d rd_addr=%h, required 0 and 0f",
                     dut_low_cnt - low0, rd_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] frame [5] = '{8'h34, 8'hFE, 8'hA1, 8'hB2, 8'hC3};
        logic ack;
        exp_wr_q.push_back({8'hFE, 8'hA1});
        exp_wr_q.push_back({8'hFF, 8'hB2});
        exp_wr_q.push_back({8'h00, 8'hC3});
        i2c_start();
        for (int i = 0; i < 5; i++) begin
            write_byte(frame[i], ack);
            checks++;
            if (ack !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ack byte %0d: got ack=%b, required 1", i, ack);
            end
        end
        i2c_stop();
        checks++;
        if (rd_addr !== 8'h01 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_wrap: got rd_addr=%h pending=%0d, required 01 and 0", rd_addr, exp_wr_q.size());
        end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] got, exp;
        reg_mem[8'h05] = 8'h5A;
        reg_mem[8'h06] = 8'hC3;
        i2c_start();
        write_byte(8'h34, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL read_ack_addr: got %b, required 1", ack); end
        write_byte(8'h05, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL read_ack_reg: got %b, required 1", ack); end
        i2c_start();
        write_byte(8'h35, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL read_ack_raddr: got %b, required 1", ack); end
        exp_rd_q.push_back(8'h5A);
        exp_rd_q.push_back(8'hC3);
        for (int i = 0; i < 2; i++) begin
            read_byte(i == 0, got);
            exp = exp_rd_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL read_byte %0d: got %h, required %h", i, got, exp);
            end else begin
                $display("read byte %0d data=%h", i, got);
            end
        end
        checks++;
        if (sda_bus !== 1'b1) begin
            errors++;
            $display("FAIL read_release_after_nack: got sda=%b, required 1", sda_bus);
        end
        i2c_stop();
        checks++;
        if (rd_addr !== 8'h07 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_after_stop: got rd_addr=%h busy=%b, required 07 and 0", rd_addr, busy);
        end
    endtask

    task automatic test_partial_stop();
        logic ack, s;
        i2c_start();
        write_byte(8'h34, ack);
        write_byte(8'h20, ack);
        for (int i = 0; i < 4; i++) bit_xfer(i[0], s);
        i2c_stop();
        wait_clk(H);
        checks++;
        if (rd_addr !== 8'h20 || busy !== 1'b0) begin
            errors++;
            $display("FAIL partial_stop: got rd_addr=%h busy=%b, required 20 and 0", rd_addr, busy);
        end
        exp_wr_q.push_back({8'h21, 8'h77});
        i2c_start();
        write_byte(8'h34, ack);
        write_byte(8'h21, ack);
        write_byte(8'h77, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL partial_next_ack: got %b, required 1", ack); end
        i2c_stop();
        checks++;
        if (rd_addr !== 8'h22 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL partial_next_frame: got rd_addr=%h pending=%0d, required 22 and 0", rd_addr, exp_wr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic ack, s;
        logic [7:0] regb;
        regb = 8'h10;
        i2c_start();
        write_byte(8'h34, ack);
        for (int i = 7; i >= 0; i--) bit_xfer(regb[i], s);
        // Ninth clock of the register byte: the target should be ACKing.
        sda_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(H / 2);
        checks++;
        if (sda_bus !== 1'b0 || rd_addr !== 8'h10) begin
            errors++;
            $display("FAIL rstmid_pre: got sda=%b rd_addr=%h, required 0 and 10", sda_bus, rd_addr);
        end
        rst = 1'b1;
        wait_clk(1);
        checks++;
        if (sda_bus !== 1'b1 || {wr_en, wr_addr, wr_data, rd_addr, busy} !== 26'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got sda=%b wr_en=%b wr_addr=%h wr_data=%h rd_addr=%h busy=%b, required sda=1 rest 0",
                     sda_bus, wr_en, wr_addr, wr_data, rd_addr, busy);
        end
        rst = 1'b0;
        wait_clk(H / 2);
        scl = 1'b0;
        wait_clk(Q);
        i2c_stop();
        exp_wr_q.push_back({8'h10, 8'h55});
        i2c_start();
        write_byte(8'h34, ack);
        write_byte(8'h10, ack);
        write_byte(8'h55, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL rstmid_next_ack: got %b, required 1", ack); end
        i2c_stop();
        checks++;
        if (exp_wr_q.size() != 0 || rd_addr !== 8'h11) begin
            errors++;
            $display("FAIL rstmid_next_frame: got pending=%0d rd_addr=%h, required 0 and 11", exp_wr_q.size(), rd_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) reg_mem[i] = 8'(i ^ 8'h96);
        test_reset();
        test_write();
        test_addr_mismatch();
        test_back_to_back();
        test_read();
        test_partial_stop();
        test_reset_mid();
        wait_clk(H);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
